// File: rtl/decoder_scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : scan_pkg
// Brief  : Shared state encoding, constants and line-search helper for the
//          decoder scan sequencer.
// Rev    : 1.0
// ============================================================================
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } scan_state_t;

  localparam logic DEC_OFF   = 1'b1;
  localparam int   NUM_LINES = 4;

  // Lowest unmasked line index >= from; bit 2 flags that one was found.
  function automatic logic [2:0] find_line(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!mask[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : decoder_scan_sequencer_if
// Brief  : Control/status bundle between a scan controller and the sequencer.
//          mask exists only when SCAN_MASK_EN is defined.
// Rev    : 1.0
// ============================================================================
interface decoder_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
  logic               dec_enable;
  logic [1:0]         dec_in;
  logic               busy;
  logic               line_done;
  logic               frame_done;
`ifdef SCAN_MASK_EN
  logic [3:0]         mask;

  modport master (
    output start, stop, dwell, mask,
    input  dec_enable, dec_in, busy, line_done, frame_done
  );
  modport slave (
    input  start, stop, dwell, mask,
    output dec_enable, dec_in, busy, line_done, frame_done
  );
`else
  modport master (
    output start, stop, dwell,
    input  dec_enable, dec_in, busy, line_done, frame_done
  );
  modport slave (
    input  start, stop, dwell,
    output dec_enable, dec_in, busy, line_done, frame_done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/decoder_scan_sequencer_timer.sv
`default_nettype none
// ============================================================================
// Module : scan_timer
// Brief  : Loadable down-counter; expire is high while the count is zero.
// Rev    : 1.0
// ============================================================================
module scan_timer #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         load,
  input  wire logic [W-1:0] value,
  output logic              expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule
`default_nettype wire

// File: rtl/decoder_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module : decoder_scan_sequencer
// Brief  : Scans the four 2-to-4 decoder lines with programmable dwell and a
//          blanking gap. Optional line skipping via macro SCAN_MASK_EN.
// Rev    : 1.0
// ============================================================================
module decoder_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input wire logic               clk,
  input wire logic               rst,
  decoder_scan_sequencer_if.slave bus
);

  localparam int TW = (DWELL_W > $clog2(BLANK_CYCLES + 1)) ? DWELL_W : $clog2(BLANK_CYCLES + 1);
  localparam logic [TW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : '0;

  scan_state_t        state, state_n;
  logic [1:0]         line, line_n;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_m1_in;
  logic [3:0]         mask_q;
  logic [3:0]         mask_in;
  logic               stop_pending;
  logic               empty_pulse, empty_n;
  logic               latch;
  logic               t_load;
  logic [TW-1:0]      t_val;
  logic               t_expire;
  logic [2:0]         next_find, first_find;
  logic               last_line, phase_end;

  // Timers are loaded with cycles-1 so a zero count marks the final cycle.
  assign dwell_m1_in = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;

`ifdef SCAN_MASK_EN
  assign mask_in = bus.mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= 4'h0;
    end else if (latch) begin
      mask_q <= mask_in;
    end
  end
`else
  assign mask_in = 4'h0;
  assign mask_q  = 4'h0;
`endif

  assign next_find  = find_line(mask_q, {1'b0, line} + 3'd1);
  assign first_find = find_line(mask_in, 3'd0);
  assign last_line  = !next_find[2];
  assign phase_end  = t_expire &&
                      (((state == ACTIVE) && (BLANK_CYCLES == 0)) || (state == BLANK));

  scan_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (t_load),
    .value  (t_val),
    .expire (t_expire)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      line  <= 2'd0;
    end else begin
      state <= state_n;
      line  <= line_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q      <= '0;
      stop_pending <= 1'b0;
      empty_pulse  <= 1'b0;
    end else begin
      empty_pulse <= empty_n;
      if (latch) dwell_q <= dwell_m1_in;
      if (state_n == IDLE) begin
        stop_pending <= 1'b0;
      end else if ((state != IDLE) && bus.stop) begin
        stop_pending <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    line_n  = line;
    t_load  = 1'b0;
    t_val   = '0;
    latch   = 1'b0;
    empty_n = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          latch = 1'b1;
          if (first_find[2]) begin
            state_n = ACTIVE;
            line_n  = first_find[1:0];
            t_load  = 1'b1;
            t_val   = TW'(dwell_m1_in);
          end else begin
            empty_n = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (t_expire && (BLANK_CYCLES > 0)) begin
          state_n = BLANK;
          t_load  = 1'b1;
          t_val   = BLANK_LOAD;
        end
      end
      default: ;
    endcase

    if (phase_end) begin
      if (!last_line) begin
        state_n = ACTIVE;
        line_n  = next_find[1:0];
        t_load  = 1'b1;
        t_val   = TW'(dwell_q);
      end else if (stop_pending) begin
        state_n = IDLE;
        line_n  = 2'd0;
      end else begin
        // Frame boundary: new dwell and mask take effect from line 0 onward.
        latch = 1'b1;
        if (first_find[2]) begin
          state_n = ACTIVE;
          line_n  = first_find[1:0];
          t_load  = 1'b1;
          t_val   = TW'(dwell_m1_in);
        end else begin
          state_n = IDLE;
          line_n  = 2'd0;
          empty_n = 1'b1;
        end
      end
    end
  end

  // Output decode, from registered state only
  always_comb begin
    bus.dec_enable = (state == ACTIVE) ? ~DEC_OFF : DEC_OFF;
    bus.dec_in     = line;
    bus.busy       = (state != IDLE);
    bus.line_done  = (state == ACTIVE) && t_expire;
    bus.frame_done = (phase_end && last_line) || empty_pulse;
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_decoder_scan_sequencer
// Brief  : Scoreboard bench for decoder_scan_sequencer (SCAN_MASK_EN optional).
// Rev    : 1.0
// ============================================================================
module tb_decoder_scan_sequencer;

  localparam int DWELL_W = 8;
  localparam int BLANK   = 2;

  typedef struct {
    int line;
    int len;
  } exp_line_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  decoder_scan_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

  decoder_scan_sequencer #(.DWELL_W(DWELL_W), .BLANK_CYCLES(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_fail   = 0;
  exp_line_t lq[$];
  int        fq[$];
  int        frames_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int d, input logic [3:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (!m[i]) begin
        lq.push_back('{line: i, len: d});
        n++;
      end
    end
    fq.push_back(n * (d + BLANK));
  endtask

  // Monitor: measures active runs, blank gaps and frame lengths
  int run = 0, gap = 0, fcnt = 0;
  bit have_prev = 1'b0;
  always @(negedge clk) begin
    exp_line_t e;
    if (rst) begin
      run = 0; gap = 0; fcnt = 0; have_prev = 1'b0;
    end else begin
      if (!bus.busy) begin
        have_prev = 1'b0; fcnt = 0; gap = 0;
      end else begin
        fcnt++;
      end
      if (!bus.dec_enable) begin
        if (run == 0 && have_prev) check("blank_gap", gap, BLANK);
        if (run == 0) gap = 0;
        run++;
      end else begin
        run = 0;
        if (bus.busy) gap++;
      end
      if (bus.line_done) begin
        if (lq.size() == 0) begin
          check("extra_line_done", 1, 0);
        end else begin
          e = lq.pop_front();
          check("line_idx", bus.dec_in, e.line);
          check("line_len", run, e.len);
        end
        run = 0; gap = 0; have_prev = 1'b1;
      end
      if (bus.frame_done) begin
        if (fq.size() == 0) check("extra_frame_done", 1, 0);
        else check("frame_len", fcnt, fq.pop_front());
        fcnt = 0;
        frames_seen++;
      end
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!bus.busy) return;
    end
    check("idle_timeout", 1, 0);
  endtask

  task automatic wait_line(input int l, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (bus.busy && !bus.dec_enable && bus.dec_in == 2'(l)) return;
    end
    check("line_timeout", 1, 0);
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (frames_seen >= target) return;
    end
    check("frame_timeout", 1, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en"},   bus.dec_enable, 1);
    check({tag, "_in"},   bus.dec_in, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.dwell = '0;
`ifdef SCAN_MASK_EN
    bus.mask  = 4'h0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    check("reset_ld", bus.line_done, 0);
    check("reset_fd", bus.frame_done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Two frames at dwell 3, stop requested in the second frame
    @(negedge clk);
    bus.dwell = 8'd3;
    push_frame(3, 4'h0);
    push_frame(3, 4'h0);
    pulse_start();
    wait_frames(frames_seen + 1, 60);
    pulse_stop();
    wait_idle(60);
    check_idle("t1_end");

    // Stop during line 1: the frame still completes
    @(negedge clk);
    push_frame(3, 4'h0);
    pulse_start();
    wait_line(1, 30);
    pulse_stop();
    wait_idle(60);
    check_idle("t3_end");

    // dwell 0 behaves as 1
    @(negedge clk);
    bus.dwell = 8'd0;
    push_frame(1, 4'h0);
    pulse_start();
    pulse_stop();
    wait_idle(40);

    // start together with stop in IDLE is refused
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("t4_stay_idle", bus.busy, 0);
    end

    // start and a dwell change mid-frame leave timing untouched
    bus.dwell = 8'd2;
    push_frame(2, 4'h0);
    pulse_start();
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.dwell = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    pulse_stop();
    wait_idle(40);

    // Asynchronous reset on line 2, then restart from line 0
    @(negedge clk);
    bus.dwell = 8'd4;
    lq.push_back('{line: 0, len: 4});
    lq.push_back('{line: 1, len: 4});
    pulse_start();
    wait_line(2, 40);
    #2 rst = 1'b1;
    #1;
    check_idle("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.dwell = 8'd1;
    push_frame(1, 4'h0);
    pulse_start();
    pulse_stop();
    wait_idle(40);

`ifdef SCAN_MASK_EN
    // Lines 0 and 2 skipped
    @(negedge clk);
    bus.dwell = 8'd2;
    bus.mask  = 4'b0101;
    push_frame(2, 4'b0101);
    pulse_start();
    pulse_stop();
    wait_idle(40);

    // Everything masked: one empty frame, no scanning
    @(negedge clk);
    bus.mask = 4'hF;
    push_frame(2, 4'hF);
    pulse_start();
    repeat (3) begin
      @(negedge clk); #1;
      check("t6_empty_idle", bus.busy, 0);
    end
    bus.mask = 4'h0;
`endif

    repeat (3) @(negedge clk);
    check("lq_drained", lq.size(), 0);
    check("fq_drained", fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
